// File: rtl/burst_write_arbiter_pkg.sv
// Shared types for the burst write arbiter: FSM state, requester id and
// the {id, length} entry kept per outstanding burst in the order FIFO.
// No ports; imported by burst_order_fifo and burst_write_arbiter.
package burst_write_arbiter_pkg;

  localparam int LEN_W = 8;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef logic req_id_t;

  typedef struct packed {
    req_id_t            id;
    logic [LEN_W-1:0]   len;
  } order_entry_t;

endpackage

// File: rtl/burst_order_fifo.sv
// Order FIFO remembering which requester owns each outstanding burst.
// Latency: push visible at head next cycle; head is a registered read (no bypass).
// Backpressure: full_o blocks new grants upstream; push+pop together keeps count, even when full.
// Ports: clk, rst_n (sync, active-low), push_i/push_dat_i, pop_i, head_dat_o, full_o, empty_o.
module burst_order_fifo
  import burst_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  order_entry_t push_dat_i,
  input  logic         pop_i,
  output order_entry_t head_dat_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  order_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign head_dat_o = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a full FIFO may still accept.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/burst_write_arbiter.sv
// Two-requester burst write arbiter onto one shared address/data/response pipeline.
// Latency: grant registered one cycle after addr_valid in IDLE; addr/data/response paths combinational.
// Backpressure: readies mirror the pipeline for the granted/head requester; grants stall while the order FIFO is full.
// Ports: clk, rst_n (sync, active-low); s0_*/s1_* requester addr, data and response channels;
//        m_addr/m_length/m_addr_valid/m_addr_ready, m_data/m_data_valid/m_data_ready, m_response/m_valid/m_ready.
// Build option: BURST_ARB_ROUND_ROBIN_EN selects round-robin tie-break (default fixed priority, s0 wins).
module burst_write_arbiter
  import burst_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int MAX_BURST_LENGTH = 4,
  parameter int ORDER_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [LEN_W-1:0]      s0_length,
  input  logic                  s0_addr_valid,
  output logic                  s0_addr_ready,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s0_data_valid,
  output logic                  s0_data_ready,
  output logic [ADDR_WIDTH-1:0] s0_response,
  output logic                  s0_valid,
  input  logic                  s0_ready,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [LEN_W-1:0]      s1_length,
  input  logic                  s1_addr_valid,
  output logic                  s1_addr_ready,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  s1_data_valid,
  output logic                  s1_data_ready,
  output logic [ADDR_WIDTH-1:0] s1_response,
  output logic                  s1_valid,
  input  logic                  s1_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [LEN_W-1:0]      m_length,
  output logic                  m_addr_valid,
  input  logic                  m_addr_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_data_valid,
  input  logic                  m_data_ready,
  input  logic [ADDR_WIDTH-1:0] m_response,
  input  logic                  m_valid,
  output logic                  m_ready
);

  // Lengths are forwarded unchecked; only make sure the parameter fits the 8-bit field.
  if (MAX_BURST_LENGTH < 1 || MAX_BURST_LENGTH > (1 << LEN_W)) begin : g_len_chk
    $error("MAX_BURST_LENGTH does not fit the length field");
  end

  state_e           state_q, state_d;
  req_id_t          grant_q, grant_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] rsp_left_q, rsp_left_d, rsp_rem;
  logic             rsp_busy_q, rsp_busy_d;
  req_id_t          winner;
  order_entry_t     head, push_dat;
  logic             fifo_full, fifo_empty, push, pop;
  logic             g_addr_vld, g_data_vld, addr_hs, data_hs, rsp_on, rsp_hs;

`ifdef BURST_ARB_ROUND_ROBIN_EN
  // rr_q names the requester that wins the next tie.
  req_id_t rr_q, rr_d;
  assign winner = (s0_addr_valid && s1_addr_valid) ? rr_q : s1_addr_valid;
`else
  assign winner = !s0_addr_valid;
`endif

  assign g_addr_vld = grant_q ? s1_addr_valid : s0_addr_valid;
  assign g_data_vld = grant_q ? s1_data_valid : s0_data_valid;
  assign m_addr     = grant_q ? s1_addr   : s0_addr;
  assign m_length   = grant_q ? s1_length : s0_length;
  assign m_data     = grant_q ? s1_data   : s0_data;

  // rst_n gating keeps every handshake output quiet while reset is applied.
  assign m_addr_valid  = rst_n && (state_q == ST_ADDR) && g_addr_vld;
  assign m_data_valid  = rst_n && (state_q == ST_DATA) && g_data_vld;
  assign s0_addr_ready = rst_n && (state_q == ST_ADDR) && !grant_q && m_addr_ready;
  assign s1_addr_ready = rst_n && (state_q == ST_ADDR) &&  grant_q && m_addr_ready;
  assign s0_data_ready = rst_n && (state_q == ST_DATA) && !grant_q && m_data_ready;
  assign s1_data_ready = rst_n && (state_q == ST_DATA) &&  grant_q && m_data_ready;
  assign addr_hs       = m_addr_valid && m_addr_ready;
  assign data_hs       = m_data_valid && m_data_ready;

  // Responses return in burst order; the FIFO head says who owns them.
  assign rsp_on      = rst_n && !fifo_empty;
  assign m_ready     = rsp_on && (head.id ? s1_ready : s0_ready);
  assign s0_valid    = rsp_on && !head.id && m_valid;
  assign s1_valid    = rsp_on &&  head.id && m_valid;
  assign s0_response = m_response;
  assign s1_response = m_response;
  assign rsp_hs      = m_valid && m_ready;
  // First beat of a head burst takes its count straight from the head entry.
  assign rsp_rem     = rsp_busy_q ? rsp_left_q : head.len;
  assign pop         = rsp_hs && (rsp_rem == '0);

  assign push         = addr_hs;
  assign push_dat.id  = grant_q;
  assign push_dat.len = m_length;

  burst_order_fifo #(.DEPTH(ORDER_DEPTH)) u_order_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_dat_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_d     = beat_q;
    rsp_busy_d = rsp_busy_q;
    rsp_left_d = rsp_left_q;
`ifdef BURST_ARB_ROUND_ROBIN_EN
    rr_d       = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if ((s0_addr_valid || s1_addr_valid) && !fifo_full) begin
          grant_d = winner;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (addr_hs) begin
          beat_d  = m_length;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (data_hs) begin
          if (beat_q == '0) begin
            state_d = ST_IDLE;
`ifdef BURST_ARB_ROUND_ROBIN_EN
            rr_d    = !grant_q;
`endif
          end else begin
            beat_d = beat_q - LEN_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rsp_hs) begin
      rsp_busy_d = (rsp_rem != '0);
      rsp_left_d = rsp_rem - LEN_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      beat_q     <= '0;
      rsp_busy_q <= 1'b0;
      rsp_left_q <= '0;
`ifdef BURST_ARB_ROUND_ROBIN_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_q     <= beat_d;
      rsp_busy_q <= rsp_busy_d;
      rsp_left_q <= rsp_left_d;
`ifdef BURST_ARB_ROUND_ROBIN_EN
      rr_q       <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_burst_write_arbiter.sv
// Directed bench for burst_write_arbiter: single burst, tie-break, order-FIFO
// backpressure, length-0 burst and reset in mid-burst, all with hand-computed values.
module tb_burst_write_arbiter;
  import burst_write_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s0_addr, s1_addr, s0_data, s1_data, s0_response, s1_response;
  logic [7:0]  s0_length, s1_length, m_length;
  logic        s0_addr_valid, s0_addr_ready, s0_data_valid, s0_data_ready, s0_valid, s0_ready;
  logic        s1_addr_valid, s1_addr_ready, s1_data_valid, s1_data_ready, s1_valid, s1_ready;
  logic [31:0] m_addr, m_data, m_response;
  logic        m_addr_valid, m_addr_ready, m_data_valid, m_data_ready, m_valid, m_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  burst_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s0_addr(s0_addr), .s0_length(s0_length), .s0_addr_valid(s0_addr_valid), .s0_addr_ready(s0_addr_ready),
    .s0_data(s0_data), .s0_data_valid(s0_data_valid), .s0_data_ready(s0_data_ready),
    .s0_response(s0_response), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_addr(s1_addr), .s1_length(s1_length), .s1_addr_valid(s1_addr_valid), .s1_addr_ready(s1_addr_ready),
    .s1_data(s1_data), .s1_data_valid(s1_data_valid), .s1_data_ready(s1_data_ready),
    .s1_response(s1_response), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .m_addr(m_addr), .m_length(m_length), .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready),
    .m_data(m_data), .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
    .m_response(m_response), .m_valid(m_valid), .m_ready(m_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input bit id, input logic [31:0] a, input logic [7:0] len, input logic v);
    if (id) begin s1_addr = a; s1_length = len; s1_addr_valid = v; end
    else    begin s0_addr = a; s0_length = len; s0_addr_valid = v; end
  endtask

  task automatic set_data(input bit id, input logic [31:0] d, input logic v);
    if (id) begin s1_data = d; s1_data_valid = v; end
    else    begin s0_data = d; s0_data_valid = v; end
  endtask

  task automatic set_rdy(input bit id, input logic r);
    if (id) s1_ready = r; else s0_ready = r;
  endtask

  function automatic logic addr_rdy(input bit id);
    return id ? s1_addr_ready : s0_addr_ready;
  endfunction

  function automatic logic data_rdy(input bit id);
    return id ? s1_data_ready : s0_data_ready;
  endfunction

  function automatic logic rsp_vld(input bit id);
    return id ? s1_valid : s0_valid;
  endfunction

  // Full address + data phase for requester id, pipeline always ready.
  task automatic run_burst(input bit id, input logic [31:0] a, input logic [7:0] len, input logic [31:0] dbase);
    set_addr(id, a, len, 1'b1);
    tick();
    chk("adr_vld", m_addr_valid, 1);
    chk("adr", m_addr, a);
    chk("len", m_length, len);
    chk("adr_rdy_grant", addr_rdy(id), 1);
    chk("adr_rdy_other", addr_rdy(!id), 0);
    tick();
    set_addr(id, 0, 0, 1'b0);
    for (int i = 0; i <= int'(len); i++) begin
      set_data(id, dbase + i, 1'b1);
      #1;
      chk("dat_vld", m_data_valid, 1);
      chk("dat", m_data, dbase + i);
      chk("dat_rdy_grant", data_rdy(id), 1);
      chk("dat_rdy_other", data_rdy(!id), 0);
      tick();
    end
    chk("idle_after_burst", 32'(dut.state_q), 32'(ST_IDLE));
    chk("idle_dat_rdy", data_rdy(id), 0);
    set_data(id, 0, 1'b0);
  endtask

  task automatic run_resp(input bit id, input logic [31:0] base, input logic [7:0] len);
    set_rdy(id, 1'b1);
    for (int i = 0; i <= int'(len); i++) begin
      m_valid = 1'b1;
      m_response = base + i;
      #1;
      chk("rsp_vld_owner", rsp_vld(id), 1);
      chk("rsp_vld_other", rsp_vld(!id), 0);
      chk("rsp_dat", id ? s1_response : s0_response, base + i);
      chk("m_ready", m_ready, 1);
      tick();
    end
    m_valid = 1'b0;
    set_rdy(id, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    s0_addr = '0; s0_length = '0; s0_addr_valid = 0; s0_data = '0; s0_data_valid = 0; s0_ready = 0;
    s1_addr = '0; s1_length = '0; s1_addr_valid = 0; s1_data = '0; s1_data_valid = 0; s1_ready = 0;
    m_addr_ready = 1'b1; m_data_ready = 1'b1; m_response = '0; m_valid = 1'b0;

    // Reset: outputs quiet even with valids/readies asserted.
    tick(); tick();
    s0_addr_valid = 1; m_valid = 1; s0_ready = 1; s1_ready = 1;
    #1;
    chk("rst_adr_vld", m_addr_valid, 0);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_s0_valid", s0_valid, 0);
    chk("rst_s0_adr_rdy", s0_addr_ready, 0);
    s0_addr_valid = 0; m_valid = 0; s0_ready = 0; s1_ready = 0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("post_rst_dat_vld", m_data_valid, 0);
    chk("post_rst_s1_valid", s1_valid, 0);

    // Single burst from s0, then its four responses.
    run_burst(0, 32'h10, 8'd3, 32'h10);
    run_resp(0, 32'h10, 8'd3);
    m_valid = 1; #1;
    chk("empty_m_ready", m_ready, 0);
    chk("empty_s0_valid", s0_valid, 0);
    chk("empty_s1_valid", s1_valid, 0);
    m_valid = 0;

    // Length 0 from s1.
    run_burst(1, 32'h20, 8'd0, 32'h20);
    run_resp(1, 32'h20, 8'd0);

    // Tie from IDLE.
    set_addr(1, 32'h30, 8'd0, 1'b1);
`ifdef BURST_ARB_ROUND_ROBIN_EN
    run_burst(0, 32'h34, 8'd0, 32'h34);
    run_burst(1, 32'h30, 8'd0, 32'h30);
    run_resp(0, 32'h34, 8'd0);
    run_resp(1, 32'h30, 8'd0);
`else
    run_burst(0, 32'h34, 8'd0, 32'h34);
    run_burst(0, 32'h38, 8'd0, 32'h38);
    set_addr(1, 32'h0, 8'd0, 1'b0);
    run_resp(0, 32'h34, 8'd0);
    run_resp(0, 32'h38, 8'd0);
`endif

    // Backpressure: fill the order FIFO with four unanswered bursts.
    for (int k = 0; k < 4; k++) run_burst(0, 32'h40 + k, 8'd0, 32'h40 + k);
    set_addr(0, 32'h50, 8'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("full_adr_rdy", s0_addr_ready, 0);
      chk("full_adr_vld", m_addr_valid, 0);
    end
    m_valid = 1; m_response = 32'h40; s0_ready = 1; #1;
    chk("full_rsp_vld", s0_valid, 1);
    tick();
    m_valid = 0; s0_ready = 0; #1;
    chk("pop_edge_no_grant", s0_addr_ready, 0);
    tick();
    chk("grant_after_pop", s0_addr_ready, 1);
    chk("grant_after_pop_adr", m_addr, 32'h50);
    tick();
    set_addr(0, 0, 0, 1'b0);
    set_data(0, 32'h50, 1'b1);
    tick();
    set_data(0, 0, 1'b0);
    for (int k = 1; k < 4; k++) run_resp(0, 32'h40 + k, 8'd0);
    run_resp(0, 32'h50, 8'd0);

    // Reset after beat 2 of a length-3 burst.
    set_addr(0, 32'h60, 8'd3, 1'b1);
    tick(); tick();
    set_addr(0, 0, 0, 1'b0);
    set_data(0, 32'h60, 1'b1); tick();
    set_data(0, 32'h61, 1'b1); tick();
    rst_n = 0; m_valid = 1; s0_ready = 1;
    set_data(0, 32'h62, 1'b1);
    #1;
    chk("rst_mid_dat_rdy", s0_data_ready, 0);
    chk("rst_mid_s0_valid", s0_valid, 0);
    tick();
    rst_n = 1; #1;
    chk("rst_mid_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rst_mid_m_ready", m_ready, 0);
    chk("rst_mid_s0_valid2", s0_valid, 0);
    tick();
    chk("rst_mid_no_beat", m_data_valid, 0);
    chk("rst_mid_no_rsp", s0_valid, 0);
    set_data(0, 0, 1'b0); m_valid = 0; s0_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_write_arbiter.md
BURST_WRITE_ARBITER -- requirements
Module: burst_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data width in bits, SHALL be provided.
REQ-002 Parameter ADDR_WIDTH, default 32, address and response width in bits, SHALL be provided.
REQ-003 Parameter MAX_BURST_LENGTH, default 4, maximum beats per burst, SHALL be provided.
REQ-004 Parameter ORDER_DEPTH, default 4 (power of 2), sets the outstanding-burst order FIFO depth, SHALL be provided.
REQ-005 clk  input  1  is the single clock; all logic SHALL be rising-edge.
REQ-006 rst_n  input  1  is the reset, synchronous and active-low.
REQ-007 sN_addr / sN_length  input  ADDR_WIDTH / 8  are requester N's (N=0,1) start address and length-1.
REQ-008 sN_addr_valid input 1, sN_addr_ready output 1 form the requester N address handshake.
REQ-009 sN_data input DATA_WIDTH, sN_data_valid input 1, sN_data_ready output 1 form the requester N write-data handshake.
REQ-010 sN_response output ADDR_WIDTH, sN_valid output 1, sN_ready input 1 form the requester N per-beat response handshake.
REQ-011 m_addr, m_length, m_addr_valid (outputs) and m_addr_ready (input) SHALL drive the shared burst write pipeline address port.
REQ-012 m_data, m_data_valid (outputs) and m_data_ready (input) SHALL drive the pipeline data port.
REQ-013 m_response, m_valid (inputs) and m_ready (output) SHALL take the pipeline per-beat response.

Function
REQ-014 A 3-state FSM SHALL be implemented: IDLE, ADDR, DATA.
REQ-015 In IDLE, when at least one sN_addr_valid is high and the order FIFO is not full, the FSM SHALL register a grant and go to ADDR on the next edge.
REQ-016 In IDLE, while the order FIFO is full, no grant SHALL be made.
REQ-017 In ADDR:
  - m_addr, m_length and m_addr_valid SHALL combinationally mirror the granted requester.
  - sN_addr_ready SHALL equal m_addr_ready for the granted requester and 0 for the other.
REQ-018 On an ADDR handshake, the FSM SHALL:
  - load beat counter = m_length;
  - push {grant id, m_length} into the order FIFO;
  - go to DATA.
REQ-019 In DATA:
  - m_data and m_data_valid SHALL mirror the granted requester.
  - sN_data_ready SHALL equal m_data_ready for the granted requester and 0 otherwise.
  - The beat counter SHALL decrement per handshake.
REQ-020 A DATA handshake with beat counter == 0 SHALL return the FSM to IDLE; length 0 means a single beat.
REQ-021 sN_addr_ready and sN_data_ready SHALL both be 0 in IDLE, and for the non-granted requester at all times.
REQ-022 Responses SHALL be routed using the order FIFO head:
  - sN_valid = m_valid for the head id only;
  - m_ready = ready of the head id;
  - a response beat counter is loaded from the head length.
REQ-023 The FIFO head SHALL pop on the last response handshake of its burst.
REQ-024 With the order FIFO empty, m_ready SHALL be 0 and both sN_valid SHALL be 0.
REQ-025 FIFO push and pop in the same cycle SHALL both take effect and leave the count unchanged, including when the FIFO is full.
REQ-026 sN_response SHALL equal m_response for both requesters.
REQ-027 m_length SHALL be forwarded unmodified; no range check against MAX_BURST_LENGTH SHALL be done.

Reset
REQ-028 When rst_n = 0 at a clock edge:
  - the FSM SHALL go to IDLE;
  - both counters and the FIFO pointers and count SHALL clear;
  - the round-robin pointer SHALL be 0.
REQ-029 All valid/ready outputs SHALL be 0 during and right after reset, and any burst in progress SHALL be abandoned with no further beats.

Configuration
REQ-030 With BURST_ARB_ROUND_ROBIN_EN defined, the grant SHALL be round-robin:
  - the requester after the last-granted one wins ties;
  - the pointer updates on each DATA-to-IDLE transition.
REQ-031 Without BURST_ARB_ROUND_ROBIN_EN, the grant SHALL be fixed-priority, with requester 0 winning ties and no pointer state.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE/ADDR/DATA), the requester-id type and the order-entry {id, length} type.
REQ-033 The order FIFO SHALL be a sub-module named burst_order_fifo with full/empty outputs.

Verification
REQ-034 Single burst: s0 addr 0x10, length 3, data 0x10..0x13 -> 4 beats forwarded in order, s0 receives responses 0x10..0x13, s1 sees none.
REQ-035 Tie: s0 and s1 both request from IDLE, RR build -> s0 granted first, then s1; fixed-priority build with s0 requesting continuously -> s1 never granted.
REQ-036 Backpressure: order FIFO filled with 4 bursts and sN_ready held 0 -> no grant and sN_addr_ready = 0 until a response burst completes.
REQ-037 Length 0: s1 addr 0x20, data 0x20 -> one data beat, FSM back in IDLE the cycle after the handshake, s1 gets one response 0x20.
REQ-038 Reset mid-burst: rst_n low after beat 2 of a length-3 burst -> FSM is IDLE and FIFO empty the next cycle, with no stray sN_valid.
